// File: rtl/fb_ctrl_pkg.sv
// fb_scan_ctrl shared definitions: VGA timing defaults, framebuffer depth
// and the writer state encoding.
package fb_ctrl_pkg;

    localparam int PIX_W = 4;
    localparam int CNT_W = 17;
    localparam int FB_DEPTH = 76800;

    localparam int H_ACTIVE_D = 640;
    localparam int H_FP_D = 16;
    localparam int H_SYNC_D = 96;
    localparam int H_BP_D = 48;
    localparam int V_ACTIVE_D = 480;
    localparam int V_FP_D = 10;
    localparam int V_SYNC_D = 2;
    localparam int V_BP_D = 33;

    localparam int H_TOTAL = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
    localparam int V_TOTAL = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;
    localparam int HS_START = H_ACTIVE_D + H_FP_D;
    localparam int HS_END = HS_START + H_SYNC_D;
    localparam int VS_START = V_ACTIVE_D + V_FP_D;
    localparam int VS_END = VS_START + V_SYNC_D;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SYNC,
        FILL,
        DONE
    } wr_state_t;

endpackage

// File: rtl/fb_scan_ctrl_if.sv
// Render stream, framebuffer port and video pins of fb_scan_ctrl.
// master = render core / framebuffer side, slave = the controller.
interface fb_scan_ctrl_if;
    import fb_ctrl_pkg::*;

    logic             frame_req;
    logic [PIX_W-1:0] pix_in;
    logic             pix_valid;
    logic             pix_ready;
    logic             frame_done;
    logic [PIX_W-1:0] fb_in;
    logic             fb_write;
    logic             fb_reset_write_ptr;
    logic [PIX_W-1:0] fb_out;
    logic             fb_read;
    logic             fb_reset_read_ptr;
    logic             hsync;
    logic             vsync;
    logic             de;
    logic [PIX_W-1:0] pixel;

    modport master (
        output frame_req, pix_in, pix_valid, fb_out,
        input  pix_ready, frame_done, fb_in, fb_write,
        input  fb_reset_write_ptr, fb_read, fb_reset_read_ptr,
        input  hsync, vsync, de, pixel
    );

    modport slave (
        input  frame_req, pix_in, pix_valid, fb_out,
        output pix_ready, frame_done, fb_in, fb_write,
        output fb_reset_write_ptr, fb_read, fb_reset_read_ptr,
        output hsync, vsync, de, pixel
    );

endinterface

// File: rtl/fb_scan_ctrl_vga_timing.sv
// VGA raster counters with raw sync/de, window decode and frame-start
// strobe (first blanking line, hc=0).
module vga_timing
    import fb_ctrl_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_D,
    parameter int H_TOTAL_P  = H_TOTAL,
    parameter int HS_START_P = HS_START,
    parameter int HS_END_P   = HS_END,
    parameter int V_ACTIVE   = V_ACTIVE_D,
    parameter int V_TOTAL_P  = V_TOTAL,
    parameter int VS_START_P = VS_START,
    parameter int VS_END_P   = VS_END,
    parameter int WIN_X      = 160,
    parameter int WIN_Y      = 120,
    parameter int WIN_W      = 320,
    parameter int WIN_H      = 240
) (
    input  logic clk,
    input  logic rst,
    output logic hs_n,
    output logic vs_n,
    output logic de,
    output logic in_win,
    output logic frame_start
);

    localparam logic [9:0] HT_M1 = 10'(H_TOTAL_P - 1);
    localparam logic [9:0] VT_M1 = 10'(V_TOTAL_P - 1);
    localparam logic [9:0] HA    = 10'(H_ACTIVE);
    localparam logic [9:0] VA    = 10'(V_ACTIVE);
    localparam logic [9:0] HS0   = 10'(HS_START_P);
    localparam logic [9:0] HS1   = 10'(HS_END_P);
    localparam logic [9:0] VS0   = 10'(VS_START_P);
    localparam logic [9:0] VS1   = 10'(VS_END_P);
    localparam logic [9:0] WX0   = 10'(WIN_X);
    localparam logic [9:0] WX1   = 10'(WIN_X + WIN_W);
    localparam logic [9:0] WY0   = 10'(WIN_Y);
    localparam logic [9:0] WY1   = 10'(WIN_Y + WIN_H);

    logic [9:0] hc;
    logic [9:0] vc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == HT_M1) begin
            hc <= '0;
            vc <= (vc == VT_M1) ? '0 : vc + 10'd1;
        end else begin
            hc <= hc + 10'd1;
        end
    end

    assign hs_n = !(hc >= HS0 && hc < HS1);
    assign vs_n = !(vc >= VS0 && vc < VS1);
    assign de = (hc < HA) && (vc < VA);
    assign in_win = (hc >= WX0) && (hc < WX1) &&
                    (vc >= WY0) && (vc < WY1);
    assign frame_start = (hc == '0) && (vc == VA);

endmodule

// File: rtl/fb_scan_ctrl.sv
// Framebuffer sequencer: render-stream writer FSM plus VGA scan-out.
// Define FB_TEAR_FREE_EN to hold each fill until frame blanking.
module fb_scan_ctrl
    import fb_ctrl_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP     = H_FP_D,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP     = V_FP_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D,
    parameter int WIN_X    = 160,
    parameter int WIN_Y    = 120,
    parameter int WIN_W    = 320,
    parameter int WIN_H    = 240
) (
    input logic            clk,
    input logic            rst,
    fb_scan_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST = 17'(FB_DEPTH - 1);

    logic hs_n, vs_n, de_raw, in_win, frame_start;

    vga_timing #(
        .H_ACTIVE   (H_ACTIVE),
        .H_TOTAL_P  (H_ACTIVE + H_FP + H_SYNC + H_BP),
        .HS_START_P (H_ACTIVE + H_FP),
        .HS_END_P   (H_ACTIVE + H_FP + H_SYNC),
        .V_ACTIVE   (V_ACTIVE),
        .V_TOTAL_P  (V_ACTIVE + V_FP + V_SYNC + V_BP),
        .VS_START_P (V_ACTIVE + V_FP),
        .VS_END_P   (V_ACTIVE + V_FP + V_SYNC),
        .WIN_X      (WIN_X),
        .WIN_Y      (WIN_Y),
        .WIN_W      (WIN_W),
        .WIN_H      (WIN_H)
    ) u_tim (
        .clk         (clk),
        .rst         (rst),
        .hs_n        (hs_n),
        .vs_n        (vs_n),
        .de          (de_raw),
        .in_win      (in_win),
        .frame_start (frame_start)
    );

    wr_state_t        state;
    logic [CNT_W-1:0] count;
    logic             ready_q, done_q, wr_q, wrst_q;
    logic [PIX_W-1:0] din_q;
    logic             accept;

    assign accept = bus.pix_valid && ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            wr_q    <= 1'b0;
            wrst_q  <= 1'b0;
            din_q   <= '0;
        end else begin
            wr_q   <= 1'b0;
            wrst_q <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (bus.frame_req) begin
                        done_q <= 1'b0;
                        count  <= '0;
`ifdef FB_TEAR_FREE_EN
                        state  <= WAIT_SYNC;
`else
                        state   <= FILL;
                        ready_q <= 1'b1;
                        wrst_q  <= 1'b1;
`endif
                    end else if (state == DONE) begin
                        done_q <= 1'b1;
                    end
                end
`ifdef FB_TEAR_FREE_EN
                // pointer reset lines up with the read-side reset
                WAIT_SYNC: begin
                    if (frame_start) begin
                        state   <= FILL;
                        ready_q <= 1'b1;
                        wrst_q  <= 1'b1;
                    end
                end
`endif
                FILL: begin
                    if (accept) begin
                        wr_q  <= 1'b1;
                        din_q <= bus.pix_in;
                        count <= count + 17'd1;
                        if (count == LAST) begin
                            state   <= DONE;
                            ready_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pix_ready          = ready_q;
    assign bus.frame_done         = done_q;
    assign bus.fb_write           = wr_q;
    assign bus.fb_in              = din_q;
    assign bus.fb_reset_write_ptr = wrst_q;
    assign bus.fb_read            = in_win;
    assign bus.fb_reset_read_ptr  = frame_start;

    logic             hs1, vs1, de1, win1;
    logic             hs2, vs2, de2;
    logic [PIX_W-1:0] pix2;

    // two stages so syncs/de meet the framebuffer read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs1  <= 1'b1;
            vs1  <= 1'b1;
            de1  <= 1'b0;
            win1 <= 1'b0;
            hs2  <= 1'b1;
            vs2  <= 1'b1;
            de2  <= 1'b0;
            pix2 <= '0;
        end else begin
            hs1  <= hs_n;
            vs1  <= vs_n;
            de1  <= de_raw;
            win1 <= in_win;
            hs2  <= hs1;
            vs2  <= vs1;
            de2  <= de1;
            pix2 <= win1 ? bus.fb_out : '0;
        end
    end

    assign bus.hsync = hs2;
    assign bus.vsync = vs2;
    assign bus.de    = de2;
    assign bus.pixel = pix2;

endmodule

// File: tb/tb_fb_scan_ctrl.sv
// Directed bench for fb_scan_ctrl on a shrunken raster with a 320x240
// window; framebuffer modelled with an (index mod 16) preload.
`timescale 1ns/1ps
module tb_fb_scan_ctrl;

    localparam int HA = 328, HFP = 4, HSW = 8, HBP = 4;
    localparam int VA = 244, VFP = 2, VSW = 2, VBP = 2;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int WX = 4, WY = 2, WW = 320, WH = 240;
    localparam int DEPTH = 76800;
    localparam int FRAME = HT * VT;
    localparam int RRST_CYC = VA * HT;
    localparam int LIMIT = 3 * FRAME;
`ifdef FB_TEAR_FREE_EN
    localparam int WRST_CYC = RRST_CYC + 1;
    localparam int RDY1 = 0;
`else
    localparam int WRST_CYC = 1;
    localparam int RDY1 = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fb_scan_ctrl_if bus ();

    fb_scan_ctrl #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
        .WIN_X (WX), .WIN_Y (WY), .WIN_W (WW), .WIN_H (WH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input longint got,
                         input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string p);
        check({p, "_pix_ready"}, bus.pix_ready, 0);
        check({p, "_frame_done"}, bus.frame_done, 0);
        check({p, "_fb_write"}, bus.fb_write, 0);
        check({p, "_fb_in"}, bus.fb_in, 0);
        check({p, "_fb_rst_wptr"}, bus.fb_reset_write_ptr, 0);
        check({p, "_fb_read"}, bus.fb_read, 0);
        check({p, "_fb_rst_rptr"}, bus.fb_reset_read_ptr, 0);
        check({p, "_hsync"}, bus.hsync, 1);
        check({p, "_vsync"}, bus.vsync, 1);
        check({p, "_de"}, bus.de, 0);
        check({p, "_pixel"}, bus.pixel, 0);
    endtask

    function automatic int at(input int x, input int y);
        return y * HT + x + 2;
    endfunction

    // framebuffer model
    logic [3:0] mem [DEPTH];
    int rptr, wptr;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr <= 0;
            wptr <= 0;
            bus.fb_out <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 4'(i % 16);
        end else begin
            if (bus.fb_reset_read_ptr) rptr <= 0;
            else if (bus.fb_read) begin
                bus.fb_out <= mem[rptr % DEPTH];
                rptr <= rptr + 1;
            end
            if (bus.fb_reset_write_ptr) wptr <= 0;
            else if (bus.fb_write) begin
                mem[wptr % DEPTH] <= bus.fb_in;
                wptr <= wptr + 1;
            end
        end
    end

    int cyc;
    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else cyc <= cyc + 1;

    bit mon_on = 0;
    int rd_cnt = 0, rrst_cnt = 0, rrst_at = -1, both_cnt = 0;
    int hs_lo = 0, vs_lo = 0, de_cnt = 0;
    int wrst_cnt = 0, wrst_at = -1, wr_cnt = 0, wr_errs = 0;
    int first_wr = -1, last_wr = -1, done_at = -1;

    always @(negedge clk) begin
        if (!rst) begin
            if (mon_on && cyc < FRAME) begin
                if (bus.fb_read) rd_cnt++;
                if (bus.fb_reset_read_ptr) begin
                    rrst_cnt++;
                    rrst_at = cyc;
                end
                if (bus.fb_read && bus.fb_reset_read_ptr) both_cnt++;
            end
            if (mon_on && cyc >= 2 && cyc < FRAME + 2) begin
                if (!bus.hsync) hs_lo++;
                if (!bus.vsync) vs_lo++;
                if (bus.de) de_cnt++;
            end
            if (mon_on) begin
                if (cyc == at(WX, WY)) begin
                    check("px_win_first", bus.pixel, 0);
                    check("de_win_first", bus.de, 1);
                end
                if (cyc == at(WX + 1, WY)) check("px_win_second", bus.pixel, 1);
                if (cyc == at(WX + 15, WY)) check("px_win_16th", bus.pixel, 15);
                if (cyc == at(WX + WW, WY)) begin
                    check("px_right_of_win", bus.pixel, 0);
                    check("de_right_of_win", bus.de, 1);
                end
                if (cyc == at(WX - 1, WY + 1)) check("px_left_of_win", bus.pixel, 0);
                if (cyc == at(WX + 5, WY + 1)) check("px_row1_x5", bus.pixel, 5);
                if (cyc == at(WX + WW - 1, WY + WH - 1)) check("px_win_last", bus.pixel, 15);
                if (cyc == at(HA - 1, 0)) check("de_last_active", bus.de, 1);
                if (cyc == at(HA, 0)) check("de_first_blank", bus.de, 0);
                if (cyc == at(HA + HFP - 1, 0)) check("hsync_before", bus.hsync, 1);
                if (cyc == at(HA + HFP, 0)) check("hsync_start", bus.hsync, 0);
                if (cyc == at(HT - 1, VA + VFP - 1)) check("vsync_before", bus.vsync, 1);
                if (cyc == at(0, VA + VFP)) check("vsync_start", bus.vsync, 0);
            end
            if (bus.fb_reset_write_ptr) begin
                if (wrst_cnt == 0) wrst_at = cyc;
                wrst_cnt++;
            end
            if (bus.fb_write) begin
                if (wr_cnt == 0) first_wr = cyc;
                if (int'(bus.fb_in) != wr_cnt % 16) wr_errs++;
                wr_cnt++;
                last_wr = cyc;
            end
            if (bus.frame_done && done_at < 0) done_at = cyc;
        end
    end

    int beat;
    int snap;
    bit req_sent;
    bit found;

    initial begin
        bus.frame_req = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_in = '0;
        #1 rst = 1'b1;
        #1 check_reset_outputs("rst0");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("hc_start", dut.u_tim.hc, 0);
        check("vc_start", dut.u_tim.vc, 0);
        mon_on = 1'b1;

        bus.frame_req = 1'b1;
        @(negedge clk);
        bus.frame_req = 1'b0;
        check("rdy_after_req", bus.pix_ready, RDY1);

        beat = 0;
        req_sent = 1'b0;
        while (beat < DEPTH && cyc < LIMIT) begin
            bus.frame_req = (beat == 1000) && !req_sent;
            if (bus.frame_req) req_sent = 1'b1;
            bus.pix_valid = ($urandom_range(0, 15) != 0);
            bus.pix_in = 4'(beat % 16);
            if (bus.pix_valid && bus.pix_ready) beat++;
            @(negedge clk);
        end
        bus.pix_valid = 1'b0;
        bus.frame_req = 1'b0;
        check("fill_beats", beat, DEPTH);

        for (int i = 0; i < 8 && done_at < 0; i++) @(negedge clk);
        check("wr_count", wr_cnt, DEPTH);
        check("wr_data_errs", wr_errs, 0);
        check("wptr_rst_count", wrst_cnt, 1);
        check("wptr_rst_cycle", wrst_at, WRST_CYC);
        check("wptr_rst_first", first_wr > wrst_at, 1);
        check("done_after_last_wr", done_at - last_wr, 1);
        check("done_level", bus.frame_done, 1);
        check("done_ready", bus.pix_ready, 0);

        bus.pix_valid = 1'b1;
        repeat (4) @(negedge clk);
        bus.pix_valid = 1'b0;
        check("done_ignores_valid", wr_cnt, DEPTH);

        while (cyc < FRAME + 3) @(negedge clk);
        mon_on = 1'b0;
        check("frame_reads", rd_cnt, DEPTH);
        check("rptr_rst_count", rrst_cnt, 1);
        check("rptr_rst_cycle", rrst_at, RRST_CYC);
        check("rptr_rst_vs_read", both_cnt, 0);
        check("hsync_low_clks", hs_lo, VT * HSW);
        check("vsync_low_clks", vs_lo, VSW * HT);
        check("de_clks", de_cnt, VA * HA);

        bus.frame_req = 1'b1;
        @(negedge clk);
        bus.frame_req = 1'b0;
        check("restart_done_clr", bus.frame_done, 0);
        check("restart_wptr_rst", bus.fb_reset_write_ptr, RDY1);

        bus.pix_valid = 1'b1;
        bus.pix_in = 4'hA;
        found = 1'b0;
        for (int i = 0; i < 2 * HT && !found; i++) begin
            @(negedge clk);
            found = !bus.hsync;
        end
        check("hsync_wait", found, 1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        check("hc_restart", dut.u_tim.hc, 0);
        check("vc_restart", dut.u_tim.vc, 0);
        snap = wr_cnt;
        repeat (5) @(negedge clk);
        check("idle_ready", bus.pix_ready, 0);
        check("idle_no_write", wr_cnt - snap, 0);
        bus.pix_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
